// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: functional-unit result streams and register file write ports.
// master drives the requests, slave (the arbiter) drives ready and the write ports.
interface regfile_wb_arbiter_if #(
    parameter int NR_REQ      = 4,
    parameter int NR_WR_PORTS = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int PTR_W       = NR_REQ > 1 ? $clog2(NR_REQ) : 1
);
    logic                                   flush;
    logic [NR_REQ-1:0]                      req_valid;
    logic [NR_REQ-1:0]                      req_ready;
    logic [NR_REQ-1:0][4:0]                 req_waddr;
    logic [NR_REQ-1:0][DATA_WIDTH-1:0]      req_wdata;
    logic [NR_WR_PORTS-1:0]                 we;
    logic [NR_WR_PORTS-1:0][4:0]            waddr;
    logic [NR_WR_PORTS-1:0][DATA_WIDTH-1:0] wdata;
    logic [PTR_W-1:0]                       rr_ptr;
    modport master (
        output flush, req_valid, req_waddr, req_wdata,
        input  req_ready, we, waddr, wdata, rr_ptr
    );
    modport slave (
        input  flush, req_valid, req_waddr, req_wdata,
        output req_ready, we, waddr, wdata, rr_ptr
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register file write ports among result streams.
// x0 writes are acknowledged without a port; same-register requests are serialised by scan order.
module regfile_wb_arbiter #(
    parameter int NR_REQ      = 4,
    parameter int NR_WR_PORTS = 2,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    regfile_wb_arbiter_if.slave     bus
);
    localparam int PW = NR_REQ > 1 ? $clog2(NR_REQ) : 1;
    localparam logic [PW:0] NR = (PW+1)'(NR_REQ);
    logic [NR_REQ-1:0]                      ready;
    logic [NR_WR_PORTS-1:0]                 g_we;
    logic [NR_WR_PORTS-1:0][4:0]            g_addr;
    logic [NR_WR_PORTS-1:0][DATA_WIDTH-1:0] g_data;
    logic [NR_WR_PORTS-1:0]                 port;
    logic [31:0]                            taken;
    logic [PW-1:0]                          ptr;
    logic [PW-1:0]                          last;
    logic [PW-1:0]                          j;
    logic [PW:0]                            sum;
    logic [PW:0]                            nxt;
    logic                                   any;
    // port is a one-hot cursor over the write ports; all-zero means they are all taken
    always_comb begin
        ready  = '0;
        g_we   = '0;
        g_addr = '0;
        g_data = '0;
        taken  = '0;
        port   = NR_WR_PORTS'(1);
        last   = ptr;
        any    = 1'b0;
        sum    = '0;
        j      = '0;
        if (rst_ni && !bus.flush) begin
            for (int i = 0; i < NR_REQ; i++) begin
                sum = {1'b0, ptr} + (PW+1)'(i);
                j   = sum >= NR ? PW'(sum - NR) : PW'(sum);
                if (bus.req_valid[j]) begin
                    if (bus.req_waddr[j] == 5'd0) begin
                        ready[j] = 1'b1;
                    end else if (!taken[bus.req_waddr[j]] && port != '0) begin
                        ready[j]               = 1'b1;
                        taken[bus.req_waddr[j]] = 1'b1;
                        any                    = 1'b1;
                        last                   = j;
                        for (int k = 0; k < NR_WR_PORTS; k++) begin
                            if (port[k]) begin
                                g_we[k]   = 1'b1;
                                g_addr[k] = bus.req_waddr[j];
                                g_data[k] = bus.req_wdata[j];
                            end
                        end
                        port = port << 1;
                    end
                end
            end
        end
    end
    assign nxt           = {1'b0, last} + (PW+1)'(1);
    assign bus.req_ready = ready;
    assign bus.rr_ptr    = ptr;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.we    <= '0;
            bus.waddr <= '0;
            bus.wdata <= '0;
            ptr       <= '0;
        end else begin
            bus.we <= g_we;
            for (int k = 0; k < NR_WR_PORTS; k++) begin
                if (g_we[k]) begin
                    bus.waddr[k] <= g_addr[k];
                    bus.wdata[k] <= g_data[k];
                end
            end
            if (any) ptr <= nxt == NR ? '0 : nxt[PW-1:0];
        end
    end
    // register file invariants: no x0 writes, no two ports on one register
    always_comb begin
        for (int a = 0; a < NR_WR_PORTS; a++) begin
            if (bus.we[a]) assert (bus.waddr[a] != 5'd0);
            for (int b = a + 1; b < NR_WR_PORTS; b++) begin
                if (bus.we[a] && bus.we[b]) assert (bus.waddr[a] != bus.waddr[b]);
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios for the write-back arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;
    localparam int NR_REQ      = 4;
    localparam int NR_WR_PORTS = 2;
    localparam int DATA_WIDTH  = 64;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter_if #(.NR_REQ(NR_REQ), .NR_WR_PORTS(NR_WR_PORTS), .DATA_WIDTH(DATA_WIDTH)) bus ();

    regfile_wb_arbiter #(.NR_REQ(NR_REQ), .NR_WR_PORTS(NR_WR_PORTS), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int j, input logic [4:0] a, input logic [63:0] d);
        bus.req_waddr[j[1:0]] = a;
        bus.req_wdata[j[1:0]] = d;
    endtask

    task automatic test_reset;
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_waddr = '0;
        bus.req_wdata = '0;
        #3;
        set_req(0, 5'd5, 64'hAA);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.we !== 2'b00) begin errors++; $display("FAIL reset_we got=%b exp=00", bus.we); end
        checks++; if (bus.waddr !== '0) begin errors++; $display("FAIL reset_waddr got=%h exp=0", bus.waddr); end
        checks++; if (bus.wdata !== '0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", bus.wdata); end
        checks++; if (bus.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr got=%0d exp=0", bus.rr_ptr); end
        bus.req_valid = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick;
        checks++; if (bus.we !== 2'b00) begin errors++; $display("FAIL reset_idle_we got=%b exp=00", bus.we); end
    endtask

    task automatic test_single;
        set_req(0, 5'd5, 64'hAA);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        checks++; if (bus.we !== 2'b01) begin errors++; $display("FAIL single_we got=%b exp=01", bus.we); end
        checks++; if (bus.waddr[0] !== 5'd5) begin errors++; $display("FAIL single_waddr got=%0d exp=5", bus.waddr[0]); end
        checks++; if (bus.wdata[0] !== 64'hAA) begin errors++; $display("FAIL single_wdata got=%h exp=aa", bus.wdata[0]); end
        checks++; if (bus.rr_ptr !== 2'd1) begin errors++; $display("FAIL single_ptr got=%0d exp=1", bus.rr_ptr); end
        tick;
        checks++; if (bus.we !== 2'b00) begin errors++; $display("FAIL single_idle got=%b exp=00", bus.we); end
    endtask

    task automatic test_round_robin;
        set_req(3, 5'd9, 64'h33);
        bus.req_valid = 4'b1000;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL rr_pre_ready got=%b exp=1000", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        checks++; if (bus.rr_ptr !== 2'd0) begin errors++; $display("FAIL rr_wrap_ptr got=%0d exp=0", bus.rr_ptr); end
        checks++; if (bus.waddr[0] !== 5'd9) begin errors++; $display("FAIL rr_pre_waddr got=%0d exp=9", bus.waddr[0]); end
        for (int j = 0; j < 4; j++) set_req(j, 5'(j + 1), 64'(256 + j));
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0011) begin errors++; $display("FAIL rr_c0_ready got=%b exp=0011", bus.req_ready); end
        tick;
        bus.req_valid = 4'b1100;
        checks++; if (bus.we !== 2'b11) begin errors++; $display("FAIL rr_c0_we got=%b exp=11", bus.we); end
        checks++; if (bus.waddr[0] !== 5'd1 || bus.waddr[1] !== 5'd2) begin errors++; $display("FAIL rr_c0_waddr got=%0d,%0d exp=1,2", bus.waddr[0], bus.waddr[1]); end
        checks++; if (bus.wdata[0] !== 64'h100 || bus.wdata[1] !== 64'h101) begin errors++; $display("FAIL rr_c0_wdata got=%h,%h exp=100,101", bus.wdata[0], bus.wdata[1]); end
        checks++; if (bus.rr_ptr !== 2'd2) begin errors++; $display("FAIL rr_c0_ptr got=%0d exp=2", bus.rr_ptr); end
        #1;
        checks++; if (bus.req_ready !== 4'b1100) begin errors++; $display("FAIL rr_c1_ready got=%b exp=1100", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        checks++; if (bus.we !== 2'b11) begin errors++; $display("FAIL rr_c1_we got=%b exp=11", bus.we); end
        checks++; if (bus.waddr[0] !== 5'd3 || bus.waddr[1] !== 5'd4) begin errors++; $display("FAIL rr_c1_waddr got=%0d,%0d exp=3,4", bus.waddr[0], bus.waddr[1]); end
        checks++; if (bus.wdata[0] !== 64'h102 || bus.wdata[1] !== 64'h103) begin errors++; $display("FAIL rr_c1_wdata got=%h,%h exp=102,103", bus.wdata[0], bus.wdata[1]); end
        checks++; if (bus.rr_ptr !== 2'd0) begin errors++; $display("FAIL rr_c1_ptr got=%0d exp=0", bus.rr_ptr); end
        tick;
        checks++; if (bus.we !== 2'b00) begin errors++; $display("FAIL rr_idle got=%b exp=00", bus.we); end
    endtask

    task automatic test_same_addr;
        set_req(0, 5'd7, 64'h11);
        set_req(1, 5'd7, 64'h22);
        bus.req_valid = 4'b0011;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL same_c0_ready got=%b exp=0001", bus.req_ready); end
        tick;
        bus.req_valid = 4'b0010;
        checks++; if (bus.we !== 2'b01) begin errors++; $display("FAIL same_c0_we got=%b exp=01", bus.we); end
        checks++; if (bus.waddr[0] !== 5'd7 || bus.wdata[0] !== 64'h11) begin errors++; $display("FAIL same_c0_write got=%0d/%h exp=7/11", bus.waddr[0], bus.wdata[0]); end
        checks++; if (bus.rr_ptr !== 2'd1) begin errors++; $display("FAIL same_c0_ptr got=%0d exp=1", bus.rr_ptr); end
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL same_c1_ready got=%b exp=0010", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        checks++; if (bus.we !== 2'b01) begin errors++; $display("FAIL same_c1_we got=%b exp=01", bus.we); end
        checks++; if (bus.waddr[0] !== 5'd7 || bus.wdata[0] !== 64'h22) begin errors++; $display("FAIL same_c1_write got=%0d/%h exp=7/22", bus.waddr[0], bus.wdata[0]); end
        checks++; if (bus.rr_ptr !== 2'd2) begin errors++; $display("FAIL same_c1_ptr got=%0d exp=2", bus.rr_ptr); end
        tick;
        checks++; if (bus.we !== 2'b00) begin errors++; $display("FAIL same_idle got=%b exp=00", bus.we); end
    endtask

    task automatic test_x0;
        set_req(0, 5'd3, 64'h30);
        set_req(1, 5'd4, 64'h40);
        set_req(2, 5'd0, 64'hDEAD);
        bus.req_valid = 4'b0111;
        #1;
        checks++; if (bus.req_ready !== 4'b0111) begin errors++; $display("FAIL x0_ready got=%b exp=0111", bus.req_ready); end
        tick;
        bus.req_valid = 4'b0100;
        checks++; if (bus.we !== 2'b11) begin errors++; $display("FAIL x0_we got=%b exp=11", bus.we); end
        checks++; if (bus.waddr[0] !== 5'd3 || bus.waddr[1] !== 5'd4) begin errors++; $display("FAIL x0_waddr got=%0d,%0d exp=3,4", bus.waddr[0], bus.waddr[1]); end
        checks++; if (bus.wdata[0] !== 64'h30 || bus.wdata[1] !== 64'h40) begin errors++; $display("FAIL x0_wdata got=%h,%h exp=30,40", bus.wdata[0], bus.wdata[1]); end
        checks++; if (bus.rr_ptr !== 2'd2) begin errors++; $display("FAIL x0_ptr got=%0d exp=2", bus.rr_ptr); end
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL x0_only_ready got=%b exp=0100", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        checks++; if (bus.we !== 2'b00) begin errors++; $display("FAIL x0_only_we got=%b exp=00", bus.we); end
        checks++; if (bus.rr_ptr !== 2'd2) begin errors++; $display("FAIL x0_only_ptr got=%0d exp=2", bus.rr_ptr); end
    endtask

    task automatic test_flush;
        for (int j = 0; j < 4; j++) set_req(j, 5'(j + 1), 64'(512 + j));
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b1100) begin errors++; $display("FAIL flush_pre_ready got=%b exp=1100", bus.req_ready); end
        tick;
        bus.flush     = 1'b1;
        bus.req_valid = 4'b0011;
        checks++; if (bus.we !== 2'b11 || bus.waddr[0] !== 5'd3 || bus.waddr[1] !== 5'd4) begin errors++; $display("FAIL flush_retire got=%b %0d,%0d exp=11 3,4", bus.we, bus.waddr[0], bus.waddr[1]); end
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready got=%b exp=0000", bus.req_ready); end
        tick;
        checks++; if (bus.we !== 2'b00) begin errors++; $display("FAIL flush_we got=%b exp=00", bus.we); end
        checks++; if (bus.rr_ptr !== 2'd0) begin errors++; $display("FAIL flush_ptr got=%0d exp=0", bus.rr_ptr); end
        bus.flush = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0011) begin errors++; $display("FAIL flush_resume_ready got=%b exp=0011", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        checks++; if (bus.we !== 2'b11 || bus.waddr[0] !== 5'd1 || bus.waddr[1] !== 5'd2) begin errors++; $display("FAIL flush_resume_write got=%b %0d,%0d exp=11 1,2", bus.we, bus.waddr[0], bus.waddr[1]); end
        checks++; if (bus.wdata[0] !== 64'h200 || bus.wdata[1] !== 64'h201) begin errors++; $display("FAIL flush_resume_wdata got=%h,%h exp=200,201", bus.wdata[0], bus.wdata[1]); end
        checks++; if (bus.rr_ptr !== 2'd2) begin errors++; $display("FAIL flush_resume_ptr got=%0d exp=2", bus.rr_ptr); end
        tick;
    endtask

    task automatic test_async_reset;
        set_req(0, 5'd5, 64'h55);
        set_req(1, 5'd6, 64'h66);
        bus.req_valid = 4'b0011;
        #1;
        checks++; if (bus.req_ready !== 4'b0011) begin errors++; $display("FAIL arst_grant_ready got=%b exp=0011", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        checks++; if (bus.we !== 2'b11 || bus.rr_ptr !== 2'd2) begin errors++; $display("FAIL arst_pending got=%b ptr=%0d exp=11 ptr=2", bus.we, bus.rr_ptr); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (bus.we !== 2'b00) begin errors++; $display("FAIL arst_we got=%b exp=00", bus.we); end
        checks++; if (bus.waddr !== '0 || bus.wdata !== '0) begin errors++; $display("FAIL arst_bus got=%h/%h exp=0/0", bus.waddr, bus.wdata); end
        checks++; if (bus.rr_ptr !== 2'd0) begin errors++; $display("FAIL arst_ptr got=%0d exp=0", bus.rr_ptr); end
        set_req(0, 5'd5, 64'hAA);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL arst_ready got=%b exp=0000", bus.req_ready); end
        tick;
        checks++; if (bus.we !== 2'b00) begin errors++; $display("FAIL arst_hold_we got=%b exp=00", bus.we); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL arst_after_ready got=%b exp=0001", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        checks++; if (bus.we !== 2'b01 || bus.waddr[0] !== 5'd5 || bus.wdata[0] !== 64'hAA) begin errors++; $display("FAIL arst_after_write got=%b %0d/%h exp=01 5/aa", bus.we, bus.waddr[0], bus.wdata[0]); end
        checks++; if (bus.rr_ptr !== 2'd1) begin errors++; $display("FAIL arst_after_ptr got=%0d exp=1", bus.rr_ptr); end
        tick;
        checks++; if (bus.we !== 2'b00) begin errors++; $display("FAIL arst_after_idle got=%b exp=00", bus.we); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_same_addr;
        test_x0;
        test_flush;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
